// File: rtl/cmd_packer_pkg.sv
// cmd_packer_pkg: definitions shared by the EBI command packer and the scheduler.
//   - CMD_W           : width of one scheduler command {TIME, DATA, ADDR}
//   - *_H / *_L       : bit bounds of the command fields
//   - W_ADDR..W_TIME_HI : word index of each 16-bit EBI word within a command
//   - state_t         : packer state encoding
//   - pack_cmd()      : assembles a command word from its fields
package cmd_packer_pkg;

    localparam int unsigned CMD_W  = 80;

    localparam int unsigned TIME_H = 79;
    localparam int unsigned TIME_L = 48;
    localparam int unsigned DATA_H = 47;
    localparam int unsigned DATA_L = 16;
    localparam int unsigned ADDR_H = 15;
    localparam int unsigned ADDR_L = 0;

    localparam logic [2:0] W_ADDR    = 3'd0;
    localparam logic [2:0] W_DATA_LO = 3'd1;
    localparam logic [2:0] W_DATA_HI = 3'd2;
    localparam logic [2:0] W_TIME_LO = 3'd3;
    localparam logic [2:0] W_TIME_HI = 3'd4;

    typedef enum logic {
        StCollect = 1'b0,
        StPush    = 1'b1
    } state_t;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [31:0] time_f,
        input logic [31:0] data_f,
        input logic [15:0] addr_f
    );
        logic [CMD_W-1:0] c;
        c                = '0;
        c[TIME_H:TIME_L] = time_f;
        c[DATA_H:DATA_L] = data_f;
        c[ADDR_H:ADDR_L] = addr_f;
        return c;
    endfunction

endpackage

// File: rtl/cmd_packer.sv
// cmd_packer: assembles five 16-bit EBI words into one 80-bit scheduler command and writes it
// into the scheduler's command FIFO. Flags commands whose TIME goes backwards, and drops a
// partial command that stalls longer than TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   in_data[15:0]  in   EBI word
//   in_valid       in   in_data valid
//   in_ready       out  packer accepts a word (high while collecting)
//   flush          in   drop any partial/pending command and clear TIME history
//   err_clear      in   clear sticky error flags (a same-cycle set wins)
//   cmd_fifo_din   out  registered command {TIME[31:0], DATA[31:0], ADDR[15:0]}
//   cmd_fifo_wr_en out  FIFO write strobe
//   cmd_fifo_full  in   FIFO full
//   cmd_count      out  commands written to the FIFO, wrapping
//   err_order      out  sticky: command TIME below previous command TIME
//   err_timeout    out  sticky: partial command discarded on timeout
module cmd_packer
    import cmd_packer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             err_clear,
    output logic [CMD_W-1:0] cmd_fifo_din,
    output logic             cmd_fifo_wr_en,
    input  logic             cmd_fifo_full,
    output logic [CNT_W-1:0] cmd_count,
    output logic             err_order,
    output logic             err_timeout
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [15:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [15:0]        time_lo_q, time_lo_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        last_time_q, last_time_d;
    logic               last_valid_q, last_valid_d;
    logic               err_order_q, err_order_d;
    logic               err_timeout_q, err_timeout_d;

    logic               accept;
    logic               order_set;
    logic               timeout_set;
    logic [31:0]        new_time;

    assign in_ready       = (state_q == StCollect);
    assign accept         = in_valid && in_ready;
    // flush suppresses the write in the same cycle, so the strobe depends on it directly.
    assign cmd_fifo_wr_en = (state_q == StPush) && !cmd_fifo_full && !flush;
    assign new_time       = {in_data, time_lo_q};

    assign cmd_fifo_din   = cmd_q;
    assign cmd_count      = cnt_q;
    assign err_order      = err_order_q;
    assign err_timeout    = err_timeout_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmr_d        = tmr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        time_lo_d    = time_lo_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        last_time_d  = last_time_q;
        last_valid_d = last_valid_q;
        order_set    = 1'b0;
        timeout_set  = 1'b0;

        if (flush) begin
            // Any word accepted this cycle is dropped along with the partial command.
            state_d      = StCollect;
            idx_d        = W_ADDR;
            tmr_d        = '0;
            last_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (accept) begin
                        tmr_d = '0;
                        idx_d = idx_q + 3'd1;
                        unique case (idx_q)
                            W_ADDR:    addr_d         = in_data;
                            W_DATA_LO: data_d[15:0]   = in_data;
                            W_DATA_HI: data_d[31:16]  = in_data;
                            W_TIME_LO: time_lo_d      = in_data;
                            W_TIME_HI: begin
                                cmd_d     = pack_cmd(new_time, data_q, addr_q);
                                order_set = last_valid_q && (new_time < last_time_q);
                                idx_d     = W_ADDR;
                                state_d   = StPush;
                            end
                            default:   idx_d          = W_ADDR;
                        endcase
                    end else if ((TIMEOUT_CYCLES != 0) && (idx_q != W_ADDR)) begin
                        if (tmr_q == TMR_LAST) begin
                            idx_d       = W_ADDR;
                            tmr_d       = '0;
                            timeout_set = 1'b1;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                end
                StPush: begin
                    if (!cmd_fifo_full) begin
                        cnt_d        = cnt_q + CNT_W'(1);
                        last_time_d  = cmd_q[TIME_H:TIME_L];
                        last_valid_d = 1'b1;
                        idx_d        = W_ADDR;
                        state_d      = StCollect;
                    end
                end
                default: state_d = StCollect;
            endcase
        end

        // Set has priority over clear.
        err_order_d   = order_set   ? 1'b1 : (err_clear ? 1'b0 : err_order_q);
        err_timeout_d = timeout_set ? 1'b1 : (err_clear ? 1'b0 : err_timeout_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StCollect;
            idx_q         <= W_ADDR;
            tmr_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            time_lo_q     <= '0;
            cmd_q         <= '0;
            cnt_q         <= '0;
            last_time_q   <= '0;
            last_valid_q  <= 1'b0;
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmr_q         <= tmr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            time_lo_q     <= time_lo_d;
            cmd_q         <= cmd_d;
            cnt_q         <= cnt_d;
            last_time_q   <= last_time_d;
            last_valid_q  <= last_valid_d;
            err_order_q   <= err_order_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule

// File: doc/cmd_packer.md
# cmd_packer

- Assembles 16-bit words from the MCU external bus interface into 80-bit scheduler commands.
- Writes each complete command into the command FIFO read by the scheduler.
- Checks that command timestamps are non-decreasing.
- Discards stalled partial commands after a timeout, and counts commands accepted into the FIFO.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1000000: idle cycles allowed mid-command before the partial command is discarded; 0 disables the timeout.
- CNT_W, default 16: width of cmd_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-low.
- in_data  input  16  word from the EBI.
- in_valid  input  1  in_data valid.
- in_ready  output  1  packer can accept a word.
- flush  input  1  synchronous discard of any partial or pending command; also clears order history.
- err_clear  input  1  clears sticky error flags.
- cmd_fifo_din  output  80  command word {TIME[31:0], DATA[31:0], ADDR[15:0]}.
- cmd_fifo_wr_en  output  1  FIFO write strobe.
- cmd_fifo_full  input  1  FIFO full.
- cmd_count  output  CNT_W  commands written to the FIFO, wrapping.
- err_order  output  1  sticky: a command's TIME was below the previous command's TIME.
- err_timeout  output  1  sticky: a partial command was discarded on timeout.

## Operation
- Word order per command:
  - w0 = ADDR[15:0]
  - w1 = DATA[15:0]
  - w2 = DATA[31:16]
  - w3 = TIME[15:0]
  - w4 = TIME[31:16]
- Handshake: a word is accepted on a clock edge where in_valid && in_ready. in_data must be held while in_valid && !in_ready.
- State machine:
  - COLLECT: in_ready=1. A 3-bit word index counts 0..4. Accepting w4 loads the full 80-bit command register and moves to PUSH.
  - PUSH: in_ready=0. cmd_fifo_wr_en = !cmd_fifo_full (combinational). On the edge where the write occurs:
    - cmd_count increments.
    - last_time ← TIME and last_valid ← 1.
    - State returns to COLLECT with index 0.
  - While cmd_fifo_full, PUSH holds indefinitely. The timeout counter does not run in PUSH.
- Order check:
  - Evaluated when w4 is accepted: if last_valid && new TIME < last_time, err_order sets.
  - The command is still pushed; the check only flags.
  - The comparison is unsigned, 32-bit.
- Timeout:
  - The counter runs in COLLECT while index≠0 and no word is accepted; any accept resets it.
  - When the counter reaches TIMEOUT_CYCLES-1: index→0, counter→0, err_timeout sets.
- flush:
  - Forces COLLECT, index 0, counter 0, last_valid 0. No FIFO write occurs that cycle.
  - Does not change cmd_count or the error flags.
- err_clear clears both error flags. If an error sets in the same cycle, set wins.
- cmd_count wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - state COLLECT; in_ready 1; cmd_fifo_wr_en 0.
  - cmd_fifo_din 0; cmd_count 0; err_order 0; err_timeout 0.
  - index 0; last_valid 0; timeout counter 0.
- Latency: w4 accepted on edge N → cmd_fifo_wr_en high in cycle N+1 if the FIFO is not full.
- Best-case throughput: one command per 6 cycles (5 accepts + 1 PUSH).
- cmd_fifo_din is registered and stable from PUSH entry until the next w4 accept.
- Simultaneous events:
  - flush + word accept: flush wins, the word is dropped.
  - flush in PUSH with FIFO not full: no write occurs.
  - Timeout expiry + accept in the same cycle: the accept wins, the counter resets.
- rst mid-command: the partial command is lost and all state returns to reset values immediately (asynchronous).

## Structure
- Shared package, also used by the scheduler:
  - Field bounds TIME_H=79, TIME_L=48, DATA_H=47, DATA_L=16, ADDR_H=15, ADDR_L=0.
  - Command width 80.
  - Word-index constants W_ADDR=0 … W_TIME_HI=4.
  - State encoding.
- Single module, no sub-module. The timeout counter and order comparator are inline.

## Test plan
- Feed words 0x0012, 0xBEEF, 0xDEAD, 0x0100, 0x0000 → one write, cmd_fifo_din = 0x00000100_DEADBEEF_0012, cmd_count=1, no errors.
- Hold cmd_fifo_full=1 after w4 for 20 cycles → wr_en stays 0 and in_ready stays 0; release → exactly one write in the next cycle.
- Push commands with TIME 0x200, then 0x100 → both written, err_order=1; err_clear → err_order=0.
- TIMEOUT_CYCLES=8: send 2 words, then idle 8 cycles → err_timeout=1, index 0. The next 5 words form a correct command.
- Assert flush after 3 words → no write. Then a full command with TIME lower than the pre-flush command → err_order stays 0, since history was cleared.
- Preload cmd_count to all-ones (CNT_W=4, 15 commands) → the 16th command wraps cmd_count to 0. Assert rst mid-command → all outputs return to reset values.
